// File: rtl/dffram_pkg.sv
// dffram_dp shared types and helpers.
// Sweep FSM states and byte-enable expansion.
package dffram_pkg;

  typedef enum logic {
    INIT,
    READY
  } init_state_e;

  localparam int unsigned MaxDataWidth = 256;
  localparam int unsigned MaxBytes = MaxDataWidth / 8;

  function automatic logic [MaxDataWidth-1:0] be_to_mask(
    input logic [MaxBytes-1:0] be
  );
    logic [MaxDataWidth-1:0] m;
    m = '0;
    for (int i = 0; i < MaxBytes; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dffram_dp_if.sv
// dffram_dp memory port bundle.
// req/gnt/rvalid handshake plus write/read payload.
interface dffram_dp_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 12
);

  logic                   req;
  logic                   we;
  logic [DataWidth/8-1:0] be;
  logic [AddrWidth-1:0]   addr;
  logic [DataWidth-1:0]   wdata;
  logic                   gnt;
  logic                   rvalid;
  logic [DataWidth-1:0]   rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dffram_init_ctrl.sv
// dffram_dp post-reset zeroing sweep.
// Owns the write path until every word is cleared.
module dffram_init_ctrl
  import dffram_pkg::*;
#(
  parameter int unsigned Depth     = 4096,
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned InitZero  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 init_we_o,
  output logic [AddrWidth-1:0] init_addr_o,
  output logic                 init_done_o
);

  localparam logic [AddrWidth-1:0] LastAddr =
    AddrWidth'(Depth - 1);

  init_state_e          state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;

  // State and sweep counter; reset restarts the sweep at word 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: one zero write per cycle, READY after the last word.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_we_o   = 1'b0;
    init_addr_o = cnt_q;
    unique case (state_q)
      INIT: begin
        if (InitZero == 0) begin
          state_d = READY;
        end else begin
          init_we_o = 1'b1;
          if (cnt_q == LastAddr) begin
            state_d = READY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      READY: begin
        state_d = READY;
      end
    endcase
  end

  assign init_done_o = (state_q == READY);

endmodule

// File: rtl/dffram_dp.sv
// dffram_dp: two-port byte-masked synchronous RAM.
// Read-before-write across ports, A wins byte collisions.
module dffram_dp
  import dffram_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned Depth       = 4096,
  parameter int unsigned AddrWidth   = $clog2(Depth),
  parameter int unsigned OutReg      = 0,
  parameter int unsigned InitZero    = 1,
  parameter string       MemInitFile = ""
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        init_done_o,
  dffram_dp_if.slave  a_if,
  dffram_dp_if.slave  b_if
);

  localparam int unsigned BeWidth = DataWidth / 8;

  typedef logic [DataWidth-1:0] word_t;

  if ((DataWidth % 8 != 0) ||
      (DataWidth > MaxDataWidth)) begin : g_bad_width
    $error("dffram_dp: DataWidth must be a multiple of 8");
  end

  logic [1:0]           req, we;
  logic [BeWidth-1:0]   be    [2];
  logic [AddrWidth-1:0] addr  [2];
  word_t                wdata [2];

  assign req      = {b_if.req, a_if.req};
  assign we       = {b_if.we, a_if.we};
  assign be[0]    = a_if.be;
  assign be[1]    = b_if.be;
  assign addr[0]  = a_if.addr;
  assign addr[1]  = b_if.addr;
  assign wdata[0] = a_if.wdata;
  assign wdata[1] = b_if.wdata;

  logic                 init_we;
  logic [AddrWidth-1:0] init_addr;

  dffram_init_ctrl #(
    .Depth     (Depth),
    .AddrWidth (AddrWidth),
    .InitZero  (InitZero)
  ) u_init (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_done_o (init_done_o)
  );

  word_t mem [Depth];

  logic [1:0] acc, inr, rd, wr;
  logic       collide;
  word_t      old     [2];
  word_t      mask    [2];
  word_t      wr_word [2];
  word_t      b_only;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc[p]     = req[p] & init_done_o;
      inr[p]     = 32'(addr[p]) < Depth;
      rd[p]      = acc[p] & ~we[p];
      wr[p]      = acc[p] & we[p] & inr[p];
      old[p]     = inr[p] ? mem[addr[p]] : '0;
      mask[p]    = word_t'(be_to_mask(MaxBytes'(be[p])));
      wr_word[p] = (old[p] & ~mask[p]) |
                   (wdata[p] & mask[p]);
    end
    collide = (&wr) & (addr[0] == addr[1]);
    b_only  = mask[1] & ~mask[0];
    if (collide) begin
      wr_word[0] = (wr_word[0] & ~b_only) |
                   (wdata[1] & b_only);
    end
  end

  always_ff @(posedge clk_i) begin
    if (init_we) begin
      mem[init_addr] <= '0;
    end else begin
      if (wr[1]) mem[addr[1]] <= wr_word[1];
      if (wr[0]) mem[addr[0]] <= wr_word[0];
    end
  end

  logic [1:0] rv1_q;
  word_t      rd1_q [2];
  logic [1:0] rvalid;
  word_t      rdata [2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rv1_q    <= '0;
      rd1_q[0] <= '0;
      rd1_q[1] <= '0;
    end else begin
      rv1_q <= rd;
      if (rd[0]) rd1_q[0] <= old[0];
      if (rd[1]) rd1_q[1] <= old[1];
    end
  end

  if (OutReg != 0) begin : g_oreg
    logic [1:0] rv2_q;
    word_t      rd2_q [2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rv2_q    <= '0;
        rd2_q[0] <= '0;
        rd2_q[1] <= '0;
      end else begin
        rv2_q <= rv1_q;
        if (rv1_q[0]) rd2_q[0] <= rd1_q[0];
        if (rv1_q[1]) rd2_q[1] <= rd1_q[1];
      end
    end

    assign rvalid   = rv2_q;
    assign rdata[0] = rd2_q[0];
    assign rdata[1] = rd2_q[1];
  end else begin : g_noreg
    assign rvalid   = rv1_q;
    assign rdata[0] = rd1_q[0];
    assign rdata[1] = rd1_q[1];
  end

  assign a_if.gnt    = acc[0];
  assign a_if.rvalid = rvalid[0];
  assign a_if.rdata  = rdata[0];
  assign b_if.gnt    = acc[1];
  assign b_if.rvalid = rvalid[1];
  assign b_if.rdata  = rdata[1];

endmodule

// File: tb/tb_dffram_dp.sv
// dffram_dp directed bench.
// u16: Depth 16, OutReg 0; u12: Depth 12, OutReg 1.
module tb_dffram_dp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init16, init12;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dffram_dp_if #(.DataWidth(32), .AddrWidth(4)) a16 ();
  dffram_dp_if #(.DataWidth(32), .AddrWidth(4)) b16 ();
  dffram_dp_if #(.DataWidth(32), .AddrWidth(4)) a12 ();
  dffram_dp_if #(.DataWidth(32), .AddrWidth(4)) b12 ();

  dffram_dp #(
    .DataWidth(32), .Depth(16), .OutReg(0),
    .InitZero(1), .MemInitFile("")
  ) u16 (
    .clk_i(clk), .rst_ni(rst_n), .init_done_o(init16),
    .a_if(a16), .b_if(b16)
  );

  dffram_dp #(
    .DataWidth(32), .Depth(12), .OutReg(1),
    .InitZero(1), .MemInitFile("")
  ) u12 (
    .clk_i(clk), .rst_ni(rst_n), .init_done_o(init12),
    .a_if(a12), .b_if(b12)
  );

  task automatic idle_all();
    a16.req = 0; a16.we = 0; a16.be = 0; a16.addr = 0; a16.wdata = 0;
    b16.req = 0; b16.we = 0; b16.be = 0; b16.addr = 0; b16.wdata = 0;
    a12.req = 0; a12.we = 0; a12.be = 0; a12.addr = 0; a12.wdata = 0;
    b12.req = 0; b12.we = 0; b12.be = 0; b12.addr = 0; b12.wdata = 0;
  endtask

  task automatic cmd_a16(input logic w, input logic [3:0] e,
                         input logic [3:0] ad, input logic [31:0] d);
    a16.req = 1; a16.we = w; a16.be = e; a16.addr = ad; a16.wdata = d;
  endtask

  task automatic cmd_b16(input logic w, input logic [3:0] e,
                         input logic [3:0] ad, input logic [31:0] d);
    b16.req = 1; b16.we = w; b16.be = e; b16.addr = ad; b16.wdata = d;
  endtask

  task automatic cmd_a12(input logic w, input logic [3:0] e,
                         input logic [3:0] ad, input logic [31:0] d);
    a12.req = 1; a12.we = w; a12.be = e; a12.addr = ad; a12.wdata = d;
  endtask

  task automatic cmd_b12(input logic w, input logic [3:0] e,
                         input logic [3:0] ad, input logic [31:0] d);
    b12.req = 1; b12.we = w; b12.be = e; b12.addr = ad; b12.wdata = d;
  endtask

  task automatic test_reset();
    int t16, t12;
    t16 = -1;
    t12 = -1;
    checks++;
    if (init16 !== 1'b0 || init12 !== 1'b0) begin
      errors++;
      $display("FAIL reset_init_done got %b%b exp 00", init16, init12);
    end
    checks++;
    if (a16.rvalid !== 1'b0 || b12.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rvalid got %b%b exp 00", a16.rvalid, b12.rvalid);
    end
    checks++;
    if (a16.rdata !== 32'h0 || b12.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h %h exp 0", a16.rdata, b12.rdata);
    end
    cmd_a16(1'b1, 4'hF, 4'd0, 32'hFFFF_FFFF);
    for (int c = 1; c <= 40 && (t16 < 0 || t12 < 0); c++) begin
      @(posedge clk); #1;
      if (c <= 4) begin
        checks++;
        if (a16.gnt !== 1'b0) begin
          errors++;
          $display("FAIL init_gnt cyc %0d got %b exp 0", c, a16.gnt);
        end
      end
      if (c == 4) idle_all();
      if (init16 === 1'b1 && t16 < 0) t16 = c;
      if (init12 === 1'b1 && t12 < 0) t12 = c;
    end
    checks++;
    if (t16 != 16) begin
      errors++;
      $display("FAIL init16_cycles got %0d exp 16", t16);
    end
    checks++;
    if (t12 != 12) begin
      errors++;
      $display("FAIL init12_cycles got %0d exp 12", t12);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cmd_a16(1'b0, 4'h0, 4'(i), 32'h0);
      #1;
      checks++;
      if (a16.gnt !== 1'b1) begin
        errors++;
        $display("FAIL ready_gnt addr %0d got %b exp 1", i, a16.gnt);
      end
      @(posedge clk); #1;
      checks++;
      if (a16.rvalid !== 1'b1 || a16.rdata !== 32'h0) begin
        errors++;
        $display("FAIL zero16 addr %0d got v=%b d=%h exp v=1 d=0",
                 i, a16.rvalid, a16.rdata);
      end
    end
    @(negedge clk);
    idle_all();
    @(posedge clk); #1;
    checks++;
    if (a16.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_rvalid got %b exp 0", a16.rvalid);
    end
    for (int c = 0; c <= 13; c++) begin
      logic ev;
      @(negedge clk);
      if (c < 12) cmd_b12(1'b0, 4'h0, 4'(c), 32'h0);
      else b12.req = 1'b0;
      @(posedge clk); #1;
      ev = (c >= 1 && c <= 12);
      checks++;
      if (b12.rvalid !== ev || (ev && b12.rdata !== 32'h0)) begin
        errors++;
        $display("FAIL zero12 cyc %0d got v=%b d=%h exp v=%b d=0",
                 c, b12.rvalid, b12.rdata, ev);
      end
    end
  endtask

  task automatic test_masked_write();
    @(negedge clk);
    idle_all();
    cmd_a16(1'b1, 4'b0101, 4'd5, 32'hDEAD_BEEF);
    cmd_a12(1'b1, 4'b0101, 4'd5, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    checks++;
    if (a16.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_rvalid got %b exp 0", a16.rvalid);
    end
    @(negedge clk);
    cmd_a16(1'b0, 4'h0, 4'd5, 32'h0);
    cmd_a12(1'b0, 4'h0, 4'd5, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (a16.rvalid !== 1'b1 || a16.rdata !== 32'h00AD_00EF) begin
      errors++;
      $display("FAIL mask16_lat1 got v=%b d=%h exp v=1 d=00ad00ef",
               a16.rvalid, a16.rdata);
    end
    checks++;
    if (a12.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mask12_early got %b exp 0", a12.rvalid);
    end
    @(negedge clk);
    idle_all();
    @(posedge clk); #1;
    checks++;
    if (a12.rvalid !== 1'b1 || a12.rdata !== 32'h00AD_00EF) begin
      errors++;
      $display("FAIL mask12_lat2 got v=%b d=%h exp v=1 d=00ad00ef",
               a12.rvalid, a12.rdata);
    end
    checks++;
    if (a16.rvalid !== 1'b0 || a16.rdata !== 32'h00AD_00EF) begin
      errors++;
      $display("FAIL hold16 got v=%b d=%h exp v=0 d=00ad00ef",
               a16.rvalid, a16.rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (a12.rvalid !== 1'b0 || a12.rdata !== 32'h00AD_00EF) begin
      errors++;
      $display("FAIL hold12 got v=%b d=%h exp v=0 d=00ad00ef",
               a12.rvalid, a12.rdata);
    end
  endtask

  task automatic test_ww_collision();
    @(negedge clk);
    idle_all();
    cmd_a16(1'b1, 4'b0011, 4'd3, 32'h1111_1111);
    cmd_b16(1'b1, 4'b1111, 4'd3, 32'h2222_2222);
    @(negedge clk);
    cmd_a16(1'b1, 4'b0100, 4'd4, 32'h3333_3333);
    cmd_b16(1'b1, 4'b0001, 4'd4, 32'h4444_4444);
    @(negedge clk);
    cmd_a16(1'b0, 4'h0, 4'd3, 32'h0);
    cmd_b16(1'b0, 4'h0, 4'd4, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (a16.rvalid !== 1'b1 || a16.rdata !== 32'h2222_1111) begin
      errors++;
      $display("FAIL ww_full got v=%b d=%h exp v=1 d=22221111",
               a16.rvalid, a16.rdata);
    end
    checks++;
    if (b16.rvalid !== 1'b1 || b16.rdata !== 32'h0033_0044) begin
      errors++;
      $display("FAIL ww_part got v=%b d=%h exp v=1 d=00330044",
               b16.rvalid, b16.rdata);
    end
  endtask

  task automatic test_wr_collision();
    @(negedge clk);
    idle_all();
    cmd_a16(1'b1, 4'hF, 4'd7, 32'hAAAA_5555);
    @(negedge clk);
    cmd_a16(1'b1, 4'hF, 4'd7, 32'h1234_5678);
    cmd_b16(1'b0, 4'h0, 4'd7, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (b16.rvalid !== 1'b1 || b16.rdata !== 32'hAAAA_5555) begin
      errors++;
      $display("FAIL rbw_b_old got v=%b d=%h exp v=1 d=aaaa5555",
               b16.rvalid, b16.rdata);
    end
    @(negedge clk);
    a16.req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b16.rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rbw_b_new got %h exp 12345678", b16.rdata);
    end
    @(negedge clk);
    cmd_b16(1'b1, 4'hF, 4'd7, 32'h0F0F_0F0F);
    cmd_a16(1'b0, 4'h0, 4'd7, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (a16.rvalid !== 1'b1 || a16.rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rbw_a_old got v=%b d=%h exp v=1 d=12345678",
               a16.rvalid, a16.rdata);
    end
    @(negedge clk);
    b16.req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a16.rdata !== 32'h0F0F_0F0F) begin
      errors++;
      $display("FAIL rbw_a_new got %h exp 0f0f0f0f", a16.rdata);
    end
  endtask

  task automatic test_oob();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle_all();
      cmd_a12(1'b1, 4'hF, 4'(i), 32'hC0DE_0000 | i);
    end
    @(negedge clk);
    idle_all();
    cmd_b12(1'b1, 4'hF, 4'd13, 32'hFFFF_FFFF);
    @(negedge clk);
    cmd_b12(1'b0, 4'h0, 4'd11, 32'h0);
    @(negedge clk);
    cmd_b12(1'b0, 4'h0, 4'd13, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (b12.rvalid !== 1'b1 || b12.rdata !== 32'hC0DE_000B) begin
      errors++;
      $display("FAIL oob_pre got v=%b d=%h exp v=1 d=c0de000b",
               b12.rvalid, b12.rdata);
    end
    @(negedge clk);
    idle_all();
    @(posedge clk); #1;
    checks++;
    if (b12.rvalid !== 1'b1 || b12.rdata !== 32'h0) begin
      errors++;
      $display("FAIL oob_read got v=%b d=%h exp v=1 d=0",
               b12.rvalid, b12.rdata);
    end
    for (int c = 0; c <= 12; c++) begin
      logic [31:0] ed;
      @(negedge clk);
      if (c < 12) cmd_a12(1'b0, 4'h0, 4'(c), 32'h0);
      else a12.req = 1'b0;
      @(posedge clk); #1;
      if (c >= 1) begin
        ed = 32'hC0DE_0000 | (c - 1);
        checks++;
        if (a12.rvalid !== 1'b1 || a12.rdata !== ed) begin
          errors++;
          $display("FAIL oob_keep word %0d got v=%b d=%h exp v=1 d=%h",
                   c - 1, a12.rvalid, a12.rdata, ed);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    int t16, t12;
    bit rv_seen;
    @(negedge clk);
    idle_all();
    cmd_a16(1'b1, 4'hF, 4'd15, 32'h5A5A_5A5A);
    @(negedge clk);
    idle_all();
    cmd_a16(1'b0, 4'h0, 4'd15, 32'h0);
    cmd_b12(1'b0, 4'h0, 4'd0, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (a16.rvalid !== 1'b1 || a16.rdata !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL pre_rst got v=%b d=%h exp v=1 d=5a5a5a5a",
               a16.rvalid, a16.rdata);
    end
    rst_n = 1'b0;
    idle_all();
    #1;
    checks++;
    if (a16.rvalid !== 1'b0 || a16.rdata !== 32'h0 || init16 !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got v=%b d=%h done=%b exp 0 0 0",
               a16.rvalid, a16.rdata, init16);
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (b12.rvalid !== 1'b0) begin
        errors++;
        $display("FAIL inflight_rst got %b exp 0", b12.rvalid);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (init16 !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep got %b exp 0", init16);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t16 = -1;
    t12 = -1;
    rv_seen = 1'b0;
    for (int c = 1; c <= 40 && (t16 < 0 || t12 < 0); c++) begin
      @(posedge clk); #1;
      if (b12.rvalid !== 1'b0 || a16.rvalid !== 1'b0) rv_seen = 1'b1;
      if (init16 === 1'b1 && t16 < 0) t16 = c;
      if (init12 === 1'b1 && t12 < 0) t12 = c;
    end
    checks++;
    if (rv_seen) begin
      errors++;
      $display("FAIL rst_rvalid got 1 exp 0");
    end
    checks++;
    if (t16 != 16 || t12 != 12) begin
      errors++;
      $display("FAIL reinit_cycles got %0d/%0d exp 16/12", t16, t12);
    end
    @(negedge clk);
    cmd_a16(1'b0, 4'h0, 4'd15, 32'h0);
    cmd_b12(1'b0, 4'h0, 4'd11, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (a16.rvalid !== 1'b1 || a16.rdata !== 32'h0) begin
      errors++;
      $display("FAIL resweep16 got v=%b d=%h exp v=1 d=0",
               a16.rvalid, a16.rdata);
    end
    @(negedge clk);
    idle_all();
    @(posedge clk); #1;
    checks++;
    if (b12.rvalid !== 1'b1 || b12.rdata !== 32'h0) begin
      errors++;
      $display("FAIL resweep12 got v=%b d=%h exp v=1 d=0",
               b12.rvalid, b12.rdata);
    end
  endtask

  initial begin
    idle_all();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_masked_write();
    test_ww_collision();
    test_wr_collision();
    test_oob();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
